core_pc_gen: RTL and testbench

- Parametrised next-generation program-counter unit for the core fetch stage.
- Generates the fetch address, presents it to instruction fetch through a valid/ready handshake, and applies redirects (jumps) and pipeline holds.
- Adds a boot cycle, alignment enforcement, a redirect pulse for fetch flush, and an optional accepted-fetch counter.

---
 rtl/core_pc_gen_pkg.sv | 17 +
 rtl/core_pc_gen_if.sv | 28 ++
 rtl/core_perf_cnt.sv | 25 ++
 rtl/core_pc_gen.sv | 94 +++++++++
 tb/tb_core_pc_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: state encodings,
// hold/jump constants and default reset address and instruction size.
package core_pc_gen_pkg;

    typedef enum logic [1:0] {
        PcStBoot = 2'd0,
        PcStRun  = 2'd1,
        PcStHold = 2'd2
    } pc_state_e;

    localparam logic [2:0]  HOLD_NONE         = 3'd0;
    localparam logic [2:0]  HOLD_PC           = 3'd1;
    localparam logic        JUMP_EN           = 1'b1;
    localparam logic [31:0] PC_RST_ADDR_DEF   = 32'h0000_0000;
    localparam int          PC_INST_BYTES_DEF = 4;

endpackage

// File: rtl/core_pc_gen_if.sv
// Fetch-request bus between the PC generator (slave) and the pipeline/fetch side (master).
// Handshake: a request transfers on a rising edge when pc_valid_out=1, fetch_ready_in=1 and no
// hold is active; while valid and unaccepted, pc_out stays stable unless a jump or reset occurs.
interface core_pc_gen_if #(
    parameter int ADDR_W = 32,
    parameter int HOLD_W = 3,
    parameter int CNT_W  = 64
);
    logic              jump_flag_in;
    logic [ADDR_W-1:0] jump_addr_in;
    logic [HOLD_W-1:0] hold_flag_in;
    logic              fetch_ready_in;
    logic [ADDR_W-1:0] pc_out;
    logic              pc_valid_out;
    logic              redirect_out;
    logic              misalign_out;
    logic [CNT_W-1:0]  fetch_cnt_out;

    modport slave (
        input  jump_flag_in, jump_addr_in, hold_flag_in, fetch_ready_in,
        output pc_out, pc_valid_out, redirect_out, misalign_out, fetch_cnt_out
    );

    modport master (
        output jump_flag_in, jump_addr_in, hold_flag_in, fetch_ready_in,
        input  pc_out, pc_valid_out, redirect_out, misalign_out, fetch_cnt_out
    );
endinterface

// File: rtl/core_perf_cnt.sv
// Generic enable-driven wrapping performance counter, cleared by synchronous reset.
module core_perf_cnt #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/core_pc_gen.sv
// Fetch-stage program counter: boot cycle, valid/ready fetch handshake, jump redirect with alignment,
// pipeline hold. Optional accepted-fetch counter built when CORE_PC_FETCH_CNT_EN is defined.
module core_pc_gen
    import core_pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RST_ADDR    = ADDR_W'(PC_RST_ADDR_DEF),
    parameter int                INST_BYTES  = PC_INST_BYTES_DEF,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = int'(HOLD_PC),
    parameter int                CNT_W       = 64
) (
    input  logic            clk,
    input  logic            rst,
    core_pc_gen_if.slave    bus,
    output pc_state_e       state_o
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;
    logic              jump;
    logic              hold_act;
    logic              fire;

    assign jump     = (bus.jump_flag_in == JUMP_EN);
    assign hold_act = (bus.hold_flag_in >= HOLD_W'(HOLD_PC_LVL));
    assign fire     = (state_q == PcStRun) & bus.fetch_ready_in & ~hold_act;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        if (jump) begin
            // A jump wins over any same-cycle fire: the old request is dropped, not advanced.
            pc_d       = bus.jump_addr_in & ~LOW_MASK;
            redirect_d = 1'b1;
            misalign_d = |(bus.jump_addr_in & LOW_MASK);
            state_d    = hold_act ? PcStHold : PcStRun;
        end else begin
            unique case (state_q)
                PcStBoot: state_d = hold_act ? PcStHold : PcStRun;
                PcStRun: begin
                    if (hold_act)  state_d = PcStHold;
                    else if (fire) pc_d    = pc_q + ADDR_W'(INST_BYTES);
                end
                PcStHold: if (!hold_act) state_d = PcStRun;
                default:  state_d = PcStBoot;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PcStBoot;
            pc_q       <= RST_ADDR;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_valid_out = (state_q == PcStRun);
    assign bus.redirect_out = redirect_q;
    assign bus.misalign_out = misalign_q;
    assign state_o          = state_q;

`ifdef CORE_PC_FETCH_CNT_EN
    logic [CNT_W-1:0] fetch_cnt;

    core_perf_cnt #(
        .W (CNT_W)
    ) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (fire & ~jump),
        .cnt_o (fetch_cnt)
    );

    assign bus.fetch_cnt_out = fetch_cnt;
`else
    assign bus.fetch_cnt_out = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_pc_gen.sv
// Bench for core_pc_gen: directed vector table, hand sequences, then random traffic against
// an abstract fetch model with an accepted-address scoreboard.
module tb_core_pc_gen;
    import core_pc_gen_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int HOLD_W   = 3;
    localparam int CNT_W    = 64;
    localparam int HOLD_LVL = 1;
`ifdef CORE_PC_FETCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_pc_gen_if #(.ADDR_W(ADDR_W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus ();
    pc_state_e state_o;

    core_pc_gen #(
        .ADDR_W      (ADDR_W),
        .RST_ADDR    (32'h0),
        .INST_BYTES  (4),
        .HOLD_W      (HOLD_W),
        .HOLD_PC_LVL (HOLD_LVL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic j, input logic [31:0] a,
                         input logic [2:0] h, input logic rdy);
        rst                = r;
        bus.jump_flag_in   = j;
        bus.jump_addr_in   = a;
        bus.hold_flag_in   = h;
        bus.fetch_ready_in = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(string tag, logic [31:0] pc, logic v, logic r, logic m,
                                 logic [63:0] cnt, pc_state_e st);
        check({tag, ".pc"},       bus.pc_out,        pc);
        check({tag, ".valid"},    bus.pc_valid_out,  v);
        check({tag, ".redirect"}, bus.redirect_out,  r);
        check({tag, ".misalign"}, bus.misalign_out,  m);
        check({tag, ".cnt"},      bus.fetch_cnt_out, CNT_ON ? cnt : 64'd0);
        check({tag, ".state"},    64'(state_o),      64'(st));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        jump;
        logic [31:0] addr;
        logic [2:0]  hold;
        logic        ready;
        logic [31:0] pc;
        logic        valid;
        logic        redir;
        logic        mis;
        int          cnt;
        pc_state_e   st;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic j, logic [31:0] a, logic [2:0] h, logic rdy,
                                logic [31:0] pc, logic v, logic rd, logic m, int c, pc_state_e st);
        vec_t x;
        x.rst = r; x.jump = j; x.addr = a; x.hold = h; x.ready = rdy;
        x.pc = pc; x.valid = v; x.redir = rd; x.mis = m; x.cnt = c; x.st = st;
        return x;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] m_pc;
    logic        m_valid, m_boot, m_redir, m_mis;
    logic [63:0] m_cnt;
    logic [31:0] exp_q[$];

    task automatic model_step(input logic r, input logic j, input logic [31:0] a,
                              input logic [2:0] h, input logic rdy);
        bit held;
        held    = (int'(h) >= HOLD_LVL);
        m_redir = 1'b0;
        m_mis   = 1'b0;
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_boot = 1'b1; m_cnt = 64'd0;
        end else if (j) begin
            m_pc    = (a / 4) * 4;
            m_redir = 1'b1;
            m_mis   = (a % 4) != 0;
            m_valid = !held;
            m_boot  = 1'b0;
        end else if (m_boot) begin
            m_valid = !held;
            m_boot  = 1'b0;
        end else if (held) begin
            m_valid = 1'b0;
        end else if (m_valid && rdy) begin
            exp_q.push_back(m_pc);
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 64'd1;
        end else begin
            m_valid = 1'b1;
        end
    endtask

    initial begin
        logic        r, j, rdy, seen;
        logic [31:0] a, got;
        logic [2:0]  h;
        pc_state_e   est;

        drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0);

        // Reset, boot, stepping, backpressure, hold, jumps, wrap, reset mid-operation.
        vt.push_back(mk(1,0,32'h0,        0,1, 32'h0,        0,0,0,0, PcStBoot));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'h0,        1,0,0,0, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'h4,        1,0,0,1, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'h8,        1,0,0,2, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'hC,        1,0,0,3, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'h10,       1,0,0,4, PcStRun));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0,0,32'h0,    0,0, 32'h10,       1,0,0,4, PcStRun));
        for (int i = 0; i < 2; i++)
            vt.push_back(mk(0,0,32'h0,    1,1, 32'h10,       0,0,0,4, PcStHold));
        vt.push_back(mk(0,0,32'h0,        0,0, 32'h10,       1,0,0,4, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'h14,       1,0,0,5, PcStRun));
        vt.push_back(mk(0,0,32'h0,        1,1, 32'h14,       0,0,0,5, PcStHold));
        vt.push_back(mk(0,1,32'h200,      1,1, 32'h200,      0,1,0,5, PcStHold));
        vt.push_back(mk(0,0,32'h0,        0,0, 32'h200,      1,0,0,5, PcStRun));
        vt.push_back(mk(0,1,32'h1003,     0,1, 32'h1000,     1,1,1,5, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,0, 32'h1000,     1,0,0,5, PcStRun));
        vt.push_back(mk(0,1,32'hFFFFFFFC, 0,0, 32'hFFFFFFFC, 1,1,0,5, PcStRun));
        vt.push_back(mk(0,0,32'h0,        0,1, 32'h0,        1,0,0,6, PcStRun));
        vt.push_back(mk(0,0,32'h0,        1,1, 32'h0,        0,0,0,6, PcStHold));
        vt.push_back(mk(1,1,32'h300,      1,1, 32'h0,        0,0,0,0, PcStBoot));
        vt.push_back(mk(0,0,32'h0,        0,0, 32'h0,        1,0,0,0, PcStRun));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].jump, vt[i].addr, vt[i].hold, vt[i].ready);
            tick();
            check_outputs($sformatf("vec%0d", i), vt[i].pc, vt[i].valid, vt[i].redir,
                          vt[i].mis, 64'(vt[i].cnt), vt[i].st);
        end

        // Jump straight out of BOOT, then a jump landing while a high hold level is active.
        drive(1, 0, 32'h0, 3'd0, 0); tick();
        drive(0, 1, 32'h42, 3'd0, 1); tick();
        check_outputs("boot_jump", 32'h40, 1, 1, 1, 64'd0, PcStRun);
        drive(0, 1, 32'h80, 3'd7, 1); tick();
        check_outputs("jump_hold7", 32'h80, 0, 1, 0, 64'd0, PcStHold);
        drive(0, 0, 32'h0, HOLD_NONE, 1); tick();
        check_outputs("hold7_rel", 32'h80, 1, 0, 0, 64'd0, PcStRun);

        // Randomised traffic against the model, starting from a fresh reset.
        drive(1, 0, 32'h0, 3'd0, 0);
        model_step(1, 0, 32'h0, 3'd0, 0);
        tick();
        for (int c = 0; c < 600; c++) begin
            r   = ($urandom_range(0, 99) < 2);
            j   = ($urandom_range(0, 99) < 12);
            a   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom();
            h   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rdy = ($urandom_range(0, 99) < 70);
            drive(r, j, a, h, rdy);
            seen = bus.pc_valid_out && rdy && (int'(h) < HOLD_LVL) && !j && !r;
            got  = bus.pc_out;
            model_step(r, j, a, h, rdy);
            if (seen) begin
                if (exp_q.size() == 0) check("sb_unexpected_fire", 64'(got), 64'hDEAD);
                else                   check("sb_fire_pc", 64'(got), 64'(exp_q.pop_front()));
            end
            tick();
            est = m_boot ? PcStBoot : (m_valid ? PcStRun : PcStHold);
            check_outputs($sformatf("rnd%0d", c), m_pc, m_valid, m_redir, m_mis, m_cnt, est);
        end
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
